lockstep_store_buffer: RTL and testbench

- Sits directly downstream of the lockstep comparator in the fault-tolerant core pair.
- Buffers agreed stores (comparator address/data outputs) and commits them to memory only at a checkpoint.
- When the comparator flags a mismatch, discards all uncommitted stores and runs a recovery handshake, so memory never holds a store from a faulty interval.

---
 rtl/ft_pkg.sv | 22 ++
 rtl/ft_sync_fifo.sv | 71 +++++++
 rtl/lockstep_store_buffer.sv | 141 ++++++++++++++
 tb/tb_lockstep_store_buffer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// Shared types for the fault-tolerant store path.
//   state_e       : store buffer FSM states (RUN, DRAIN, RECOVER)
//   store_entry_t : one buffered store {addr, data} at the default widths
//   FT_DEPTH      : default number of buffered stores
package ft_pkg;

  localparam int unsigned FT_ADDR_WIDTH = 32;
  localparam int unsigned FT_DATA_WIDTH = 32;
  localparam int unsigned FT_DEPTH      = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    RECOVER = 2'd2
  } state_e;

  typedef struct packed {
    logic [FT_ADDR_WIDTH-1:0] addr;
    logic [FT_DATA_WIDTH-1:0] data;
  } store_entry_t;

endpackage

// File: rtl/ft_sync_fifo.sv
// Synchronous FIFO of store entries with flush.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i/wdata_i: enqueue wdata_i (ignored when full)
//   pop_i         : dequeue head (ignored when empty)
//   flush_i       : discard all entries (wins over push/pop)
//   full_o/empty_o: status
//   level_o       : number of stored entries
//   head_o        : oldest entry
module ft_sync_fifo
  import ft_pkg::*;
#(
  parameter type         entry_t = store_entry_t,
  parameter int unsigned DEPTH   = FT_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  entry_t                     wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output entry_t                     head_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  entry_t      mem_q [DEPTH];
  logic [PW:0] wptr_q, wptr_d;
  logic [PW:0] rptr_q, rptr_d;
  logic        do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign level_o = wptr_q - rptr_q;
  assign head_o  = mem_q[rptr_q[PW-1:0]];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_ONE;
      if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[PW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/lockstep_store_buffer.sv
// Store buffer behind the lockstep comparator. Agreed stores are held until a
// checkpoint and then written to memory in order; a comparator mismatch throws
// away every uncommitted store and requests a core rollback.
// Ports:
//   clk_i, rst_ni              : clock, synchronous active-low reset
//   valid_i, cmp_error_i       : store attempt, comparator mismatch
//   addr_i, data_i             : agreed store address/data
//   checkpoint_i               : commit request pulse
//   stall_o                    : hold both cores, store not accepted
//   mem_req_o/addr/wdata, gnt_i: memory write port (completes on req&&gnt)
//   checkpoint_done_o          : pulse when a checkpoint has fully committed
//   recovery_req_o/ack_i       : rollback handshake
//   error_count_o              : saturating mismatch count
//   level_o                    : buffered entries
module lockstep_store_buffer
  import ft_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = FT_DEPTH,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  input  logic                       cmp_error_i,
  input  logic [ADDR_WIDTH-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0]      data_i,
  input  logic                       checkpoint_i,
  output logic                       stall_o,
  output logic                       mem_req_o,
  output logic [ADDR_WIDTH-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0]      mem_wdata_o,
  input  logic                       mem_gnt_i,
  output logic                       checkpoint_done_o,
  output logic                       recovery_req_o,
  input  logic                       recovery_ack_i,
  output logic [CNT_WIDTH-1:0]       error_count_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int unsigned LW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_e               state_q, state_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] err_cnt_q;
  logic                 err_inc;

  logic    push, pop, flush;
  logic    full, empty;
  entry_t  head, wentry;

  assign wentry.addr = addr_i;
  assign wentry.data = data_i;

  ft_sync_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .flush_i (flush),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o),
    .head_o  (head)
  );

  always_comb begin
    state_d        = state_q;
    done_d         = 1'b0;
    push           = 1'b0;
    pop            = 1'b0;
    flush          = 1'b0;
    err_inc        = 1'b0;
    stall_o        = 1'b0;
    mem_req_o      = 1'b0;
    recovery_req_o = 1'b0;
    unique case (state_q)
      RUN: begin
        stall_o = valid_i && full && !cmp_error_i;
        if (valid_i && cmp_error_i) begin
          // A faulty store also cancels any checkpoint in the same cycle.
          state_d = RECOVER;
          flush   = 1'b1;
          err_inc = 1'b1;
        end else begin
          push = valid_i && !full;
          // A store blocked by a full buffer forces an implicit checkpoint;
          // a checkpoint on an empty buffer completes without draining.
          if ((valid_i && full) || (checkpoint_i && (!empty || push))) begin
            state_d = DRAIN;
          end else if (checkpoint_i) begin
            done_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        stall_o   = 1'b1;
        mem_req_o = !empty;
        pop       = mem_req_o && mem_gnt_i;
        if (empty || (pop && (level_o == LW'(1)))) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      RECOVER: begin
        stall_o        = 1'b1;
        recovery_req_o = 1'b1;
        if (recovery_ack_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign mem_addr_o        = mem_req_o ? head.addr : '0;
  assign mem_wdata_o       = mem_req_o ? head.data : '0;
  assign checkpoint_done_o = done_q;
  assign error_count_o     = err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      done_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (err_inc && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_lockstep_store_buffer.sv
module tb_lockstep_store_buffer;

  logic        clk = 1'b0;
  logic        rst_ni, valid_i, cmp_error_i, checkpoint_i, mem_gnt_i, recovery_ack_i;
  logic [31:0] addr_i, data_i;
  logic        stall_o, mem_req_o, checkpoint_done_o, recovery_req_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  error_count_o;
  logic [2:0]  level_o;

  always #5 clk = ~clk;

  lockstep_store_buffer #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (4),
    .CNT_WIDTH  (8)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .valid_i           (valid_i),
    .cmp_error_i       (cmp_error_i),
    .addr_i            (addr_i),
    .data_i            (data_i),
    .checkpoint_i      (checkpoint_i),
    .stall_o           (stall_o),
    .mem_req_o         (mem_req_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_gnt_i         (mem_gnt_i),
    .checkpoint_done_o (checkpoint_done_o),
    .recovery_req_o    (recovery_req_o),
    .recovery_ack_i    (recovery_ack_i),
    .error_count_o     (error_count_o),
    .level_o           (level_o)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   wr_cnt   = 0;
  int   req_cnt  = 0;
  int   done_cnt = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_a, hold_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Memory-side scoreboard: every granted write must match the oldest
  // committed store, and a waiting request must hold its address/data.
  always @(negedge clk) begin
    if (checkpoint_done_o) done_cnt++;
    if (mem_req_o) begin
      req_cnt++;
      if (hold_v) begin
        chk("addr_stable", {32'h0, mem_addr_o}, {32'h0, hold_a});
        chk("wdata_stable", {32'h0, mem_wdata_o}, {32'h0, hold_d});
      end
      if (mem_gnt_i) begin
        wr_cnt++;
        hold_v = 1'b0;
        chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_addr", {32'h0, mem_addr_o}, {32'h0, e.a});
          chk("wr_data", {32'h0, mem_wdata_o}, {32'h0, e.d});
        end
      end else begin
        hold_v = 1'b1;
        hold_a = mem_addr_o;
        hold_d = mem_wdata_o;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    valid_i = 1'b1;
    addr_i  = a;
    data_i  = d;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
    cyc();
    valid_i = 1'b0;
  endtask

  initial begin : stim
    int w0, d0, r0;
    bit found;
    rst_ni = 1'b0; valid_i = 1'b0; cmp_error_i = 1'b0; checkpoint_i = 1'b0;
    mem_gnt_i = 1'b1; recovery_ack_i = 1'b0; addr_i = '0; data_i = '0;
    repeat (2) cyc();
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_errcnt", 64'(error_count_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_memreq", 64'(mem_req_o), 64'd0);
    chk("rst_done", 64'(checkpoint_done_o), 64'd0);
    chk("rst_recreq", 64'(recovery_req_o), 64'd0);
    rst_ni = 1'b1;
    cyc();

    // Three stores then a checkpoint, grant always high.
    store(32'h100, 32'hA);
    store(32'h104, 32'hB);
    store(32'h108, 32'hC);
    chk("t1_level3", 64'(level_o), 64'd3);
    w0 = wr_cnt; d0 = done_cnt;
    checkpoint_i = 1'b1;
    cyc();
    checkpoint_i = 1'b0;
    chk("t1_drain_stall", 64'(stall_o), 64'd1);
    chk("t1_drain_req", 64'(mem_req_o), 64'd1);
    repeat (5) cyc();
    chk("t1_writes", 64'(wr_cnt - w0), 64'd3);
    chk("t1_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t1_level0", 64'(level_o), 64'd0);
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t1_stall_rel", 64'(stall_o), 64'd0);

    // Two stores then an erroneous store: everything discarded.
    store(32'h200, 32'h1);
    store(32'h204, 32'h2);
    valid_i = 1'b1; cmp_error_i = 1'b1; addr_i = 32'h208; data_i = 32'h3;
    #1;
    chk("t2_err_nostall", 64'(stall_o), 64'd0);
    cyc();
    valid_i = 1'b0; cmp_error_i = 1'b0;
    exp_q.delete();
    r0 = req_cnt;
    chk("t2_recreq", 64'(recovery_req_o), 64'd1);
    chk("t2_rec_stall", 64'(stall_o), 64'd1);
    chk("t2_flushed", 64'(level_o), 64'd0);
    chk("t2_errcnt", 64'(error_count_o), 64'd1);
    repeat (4) cyc();
    recovery_ack_i = 1'b1;
    #1;
    chk("t2_recreq_held", 64'(recovery_req_o), 64'd1);
    cyc();
    recovery_ack_i = 1'b0;
    chk("t2_recreq_drop", 64'(recovery_req_o), 64'd0);
    chk("t2_stall_rel", 64'(stall_o), 64'd0);
    chk("t2_no_memreq", 64'(req_cnt - r0), 64'd0);

    // Fill the buffer, fifth store forces an implicit checkpoint and retries.
    store(32'h300, 32'h30);
    store(32'h304, 32'h31);
    store(32'h308, 32'h32);
    store(32'h30C, 32'h33);
    chk("t3_level4", 64'(level_o), 64'd4);
    w0 = wr_cnt;
    valid_i = 1'b1; addr_i = 32'h110; data_i = 32'hD;
    #1;
    chk("t3_full_stall", 64'(stall_o), 64'd1);
    cyc();
    chk("t3_drain_stall", 64'(stall_o), 64'd1);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (checkpoint_done_o) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk("t3_done_seen", 64'(found), 64'd1);
    chk("t3_drained4", 64'(wr_cnt - w0), 64'd4);
    chk("t3_retry_nostall", 64'(stall_o), 64'd0);
    begin
      exp_t e;
      e.a = 32'h110;
      e.d = 32'hD;
      exp_q.push_back(e);
    end
    cyc();
    valid_i = 1'b0;
    chk("t3_retry_level1", 64'(level_o), 64'd1);
    checkpoint_i = 1'b1;
    cyc();
    checkpoint_i = 1'b0;
    repeat (3) cyc();
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t3_level0", 64'(level_o), 64'd0);

    // Drain with a slow grant: three wait cycles per entry.
    mem_gnt_i = 1'b0;
    store(32'h400, 32'h44);
    store(32'h404, 32'h55);
    w0 = wr_cnt; d0 = done_cnt;
    checkpoint_i = 1'b1;
    cyc();
    checkpoint_i = 1'b0;
    repeat (3) cyc();
    mem_gnt_i = 1'b1;
    cyc();
    mem_gnt_i = 1'b0;
    chk("t4_mid_level1", 64'(level_o), 64'd1);
    repeat (3) cyc();
    mem_gnt_i = 1'b1;
    cyc();
    repeat (2) cyc();
    chk("t4_writes2", 64'(wr_cnt - w0), 64'd2);
    chk("t4_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t4_level0", 64'(level_o), 64'd0);

    // Checkpoint coincident with an erroneous store is dropped.
    store(32'h500, 32'h5);
    d0 = done_cnt; w0 = wr_cnt;
    valid_i = 1'b1; cmp_error_i = 1'b1; checkpoint_i = 1'b1;
    cyc();
    valid_i = 1'b0; cmp_error_i = 1'b0; checkpoint_i = 1'b0;
    exp_q.delete();
    chk("t5_recreq", 64'(recovery_req_o), 64'd1);
    chk("t5_flushed", 64'(level_o), 64'd0);
    recovery_ack_i = 1'b1;
    cyc();
    recovery_ack_i = 1'b0;
    repeat (2) cyc();
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t5_no_write", 64'(wr_cnt - w0), 64'd0);
    chk("t5_errcnt2", 64'(error_count_o), 64'd2);

    // Checkpoint on an empty buffer.
    r0 = req_cnt;
    checkpoint_i = 1'b1;
    cyc();
    checkpoint_i = 1'b0;
    chk("t5_empty_done", 64'(checkpoint_done_o), 64'd1);
    chk("t5_empty_nostall", 64'(stall_o), 64'd0);
    cyc();
    chk("t5_done_pulse", 64'(checkpoint_done_o), 64'd0);
    chk("t5_empty_noreq", 64'(req_cnt - r0), 64'd0);

    // Saturating error counter.
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    chk("t6_cnt_cleared", 64'(error_count_o), 64'd0);
    for (int i = 0; i < 255; i++) begin
      valid_i = 1'b1; cmp_error_i = 1'b1;
      cyc();
      valid_i = 1'b0; cmp_error_i = 1'b0;
      recovery_ack_i = 1'b1;
      cyc();
      recovery_ack_i = 1'b0;
      if (i == 0) chk("t6_cnt1", 64'(error_count_o), 64'd1);
    end
    chk("t6_cnt_ff", 64'(error_count_o), 64'hFF);
    valid_i = 1'b1; cmp_error_i = 1'b1;
    cyc();
    valid_i = 1'b0; cmp_error_i = 1'b0;
    recovery_ack_i = 1'b1;
    cyc();
    recovery_ack_i = 1'b0;
    chk("t6_cnt_sat", 64'(error_count_o), 64'hFF);

    // Reset in the middle of a stalled drain.
    mem_gnt_i = 1'b0;
    store(32'h600, 32'h66);
    store(32'h604, 32'h67);
    checkpoint_i = 1'b1;
    cyc();
    checkpoint_i = 1'b0;
    chk("t6_drain_req", 64'(mem_req_o), 64'd1);
    rst_ni = 1'b0;
    cyc();
    exp_q.delete();
    chk("t6_rst_req", 64'(mem_req_o), 64'd0);
    chk("t6_rst_stall", 64'(stall_o), 64'd0);
    chk("t6_rst_level", 64'(level_o), 64'd0);
    chk("t6_rst_cnt", 64'(error_count_o), 64'd0);
    chk("t6_rst_recreq", 64'(recovery_req_o), 64'd0);
    chk("t6_rst_done", 64'(checkpoint_done_o), 64'd0);
    chk("t6_rst_addr", 64'(mem_addr_o), 64'd0);
    rst_ni = 1'b1;
    cyc();
    mem_gnt_i = 1'b1;
    repeat (2) cyc();
    chk("t6_post_noreq", 64'(mem_req_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
